// File: rtl/bus_pkg.sv
// Package for the registered bus arbiter/multiplexer.
//  - Default bus geometry (BUS_WIDTH, BUS_NSRC).
//  - Source-index map: which strobe bit / data slot belongs to which datapath source.
//  - sel_w(): width of a source index for a given source count.
package bus_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUS_NSRC  = 24;

  // Source index map. Lower index = higher priority (R0 wins everything).
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Index width for n sources; a single source still gets a 1-bit index.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_mux_if.sv
// Interface bundling the arbiter's data/strobe inputs and its registered outputs.
//  master : the control/datapath side - drives src_data, src_out, err_clr; observes bus state.
//  slave  : the arbiter itself - the reverse.
//  src_data        N*WIDTH  packed sources, source i at [i*WIDTH +: WIDTH]
//  src_out         N        drive strobes, bit i = source i drives
//  err_clr         1        clears conflict_sticky / conflict_count
//  bus             WIDTH    registered bus value
//  bus_valid       1        bus was driven by a source in the previous cycle
//  bus_src         SELW     index of the source currently on bus
//  conflict        1        more than one strobe in the previous cycle
//  conflict_sticky 1        latched conflict since last clear/err_clr
//  conflict_count  CNTW     saturating count of conflict cycles
interface bus_arb_mux_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N     = BUS_NSRC,
  parameter int CNTW  = 8
) ();
  localparam int SELW = sel_w(N);

  logic [N*WIDTH-1:0] src_data;
  logic [N-1:0]       src_out;
  logic               err_clr;
  logic [WIDTH-1:0]   bus;
  logic               bus_valid;
  logic [SELW-1:0]    bus_src;
  logic               conflict;
  logic               conflict_sticky;
  logic [CNTW-1:0]    conflict_count;

  modport master (
    output src_data, src_out, err_clr,
    input  bus, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );

  modport slave (
    input  src_data, src_out, err_clr,
    output bus, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );
endinterface

// File: rtl/bus_arb_mux_prio_enc.sv
// prio_enc_onehot: combinational fixed-priority encoder over a strobe vector.
//  req   in  N     request/strobe bits
//  idx   out SELW  lowest set index (0 when nothing is set)
//  any   out 1     at least one bit set
//  multi out 1     more than one bit set
module prio_enc_onehot
  import bus_pkg::*;
#(
  parameter int N    = BUS_NSRC,
  parameter int SELW = sel_w(N)
) (
  input  logic [N-1:0]    req,
  output logic [SELW-1:0] idx,
  output logic            any,
  output logic            multi
);

  // Scan high to low so the last hit, the lowest index, wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = SELW'(i);
    end
  end

  assign any   = |req;
  // req & (req-1) drops the lowest set bit; anything left means two or more.
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: registered, fixed-priority shared-bus multiplexer with contention tracking.
//  clk    in  rising-edge clock
//  clear  in  synchronous active-high reset, overrides everything
//  bif    slave modport of bus_arb_mux_if (sources, strobes, err_clr in; bus state out)
// One cycle of latency from strobe to bus. On contention the lowest-index source still
// drives the bus; conflict/sticky/count record the event for debug.
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int N         = BUS_NSRC,
  parameter bit HOLD_IDLE = 1'b1,
  parameter int CNTW      = 8
) (
  input  logic         clk,
  input  logic         clear,
  bus_arb_mux_if.slave bif
);
  localparam int              SELW    = sel_w(N);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [SELW-1:0]  win_idx;
  logic             win_any, win_multi;
  logic [WIDTH-1:0] win_data;

  logic [WIDTH-1:0] bus_q, bus_d;
  logic             vld_q;
  logic [SELW-1:0]  src_q, src_d;
  logic             conf_q;
  logic             sticky_q, sticky_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  prio_enc_onehot #(.N(N), .SELW(SELW)) u_enc (
    .req   (bif.src_out),
    .idx   (win_idx),
    .any   (win_any),
    .multi (win_multi)
  );

  // win_idx is always < N, so the slice never leaves src_data.
  assign win_data = bif.src_data[int'(win_idx)*WIDTH +: WIDTH];

  always_comb begin
    bus_d = bus_q;
    src_d = src_q;
    if (win_any) begin
      bus_d = win_data;
      src_d = win_idx;
    end else if (!HOLD_IDLE) begin
      bus_d = '0;
    end

    // A conflict on the same edge as err_clr is kept, so it is never lost.
    sticky_d = win_multi | (sticky_q & ~bif.err_clr);

    cnt_d = cnt_q;
    if (bif.err_clr)
      cnt_d = win_multi ? CNTW'(1) : '0;
    else if (win_multi && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      bus_q    <= '0;
      vld_q    <= 1'b0;
      src_q    <= '0;
      conf_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      bus_q    <= bus_d;
      vld_q    <= win_any;
      src_q    <= src_d;
      conf_q   <= win_multi;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bif.bus             = bus_q;
  assign bif.bus_valid       = vld_q;
  assign bif.bus_src         = src_q;
  assign bif.conflict        = conf_q;
  assign bif.conflict_sticky = sticky_q;
  assign bif.conflict_count  = cnt_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed, table-driven bench. Two instances share one stimulus:
//  dut_a: HOLD_IDLE=1, CNTW=8 (default configuration)
//  dut_b: HOLD_IDLE=0, CNTW=2 (idle-zero bus, fast-saturating counter)
module tb_bus_arb_mux;
  import bus_pkg::*;

  localparam int W = BUS_WIDTH;
  localparam int N = BUS_NSRC;

  logic           clk = 1'b0;
  logic           clear;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_out;
  logic           err_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arb_mux_if #(.WIDTH(W), .N(N), .CNTW(8)) ifa ();
  bus_arb_mux_if #(.WIDTH(W), .N(N), .CNTW(2)) ifb ();

  assign ifa.src_data = src_data;
  assign ifa.src_out  = src_out;
  assign ifa.err_clr  = err_clr;
  assign ifb.src_data = src_data;
  assign ifb.src_out  = src_out;
  assign ifb.err_clr  = err_clr;

  bus_arb_mux #(.WIDTH(W), .N(N), .HOLD_IDLE(1'b1), .CNTW(8)) dut_a (
    .clk (clk), .clear (clear), .bif (ifa.slave)
  );
  bus_arb_mux #(.WIDTH(W), .N(N), .HOLD_IDLE(1'b0), .CNTW(2)) dut_b (
    .clk (clk), .clear (clear), .bif (ifb.slave)
  );

  typedef struct {
    logic         clr;
    logic         eclr;
    logic [N-1:0] so;
    logic [31:0]  bus_a;
    logic         vld;
    logic [4:0]   src;
    logic         conf;
    logic         sticky;
    logic [7:0]   cnt_a;
    logic [31:0]  bus_b;
    logic [1:0]   cnt_b;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, v, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [31:0] d);
    src_data[i*W +: W] = d;
  endtask

  localparam logic [N-1:0] ONE = 1;

  initial begin
    // Default slot contents: 0xC00000ii; named sources overridden below.
    for (int i = 0; i < N; i++) set_src(i, 32'hC000_0000 | 32'(i));
    set_src(SRC_PC,  32'h0000_0100);
    set_src(SRC_R3,  32'hDEAD_BEEF);
    set_src(SRC_MDR, 32'h1234_5678);
    set_src(SRC_R1,  32'h1111_0001);
    set_src(SRC_R2,  32'h2222_0002);
    set_src(SRC_R15, 32'hF0F0_000F);

    //            clr eclr strobes                       bus_a         vld src   cf sk cntA  bus_b         cntB
    vt[0]  = '{1'b0,1'b0, '0,                          32'h0,          0, 5'd0,  0, 0, 8'd0, 32'h0,        2'd0};
    vt[1]  = '{1'b0,1'b0, ONE<<SRC_PC,                 32'h0000_0100,  1, 5'd20, 0, 0, 8'd0, 32'h0000_0100,2'd0};
    vt[2]  = '{1'b0,1'b0, '0,                          32'h0000_0100,  0, 5'd20, 0, 0, 8'd0, 32'h0,        2'd0};
    vt[3]  = '{1'b0,1'b0, (ONE<<SRC_R3)|(ONE<<SRC_MDR),32'hDEAD_BEEF,  1, 5'd3,  1, 1, 8'd1, 32'hDEAD_BEEF,2'd1};
    vt[4]  = '{1'b0,1'b0, '0,                          32'hDEAD_BEEF,  0, 5'd3,  0, 1, 8'd1, 32'h0,        2'd1};
    vt[5]  = '{1'b0,1'b0, (ONE<<SRC_R3)|(ONE<<SRC_MDR),32'hDEAD_BEEF,  1, 5'd3,  1, 1, 8'd2, 32'hDEAD_BEEF,2'd2};
    vt[6]  = '{1'b0,1'b0, (ONE<<SRC_R3)|(ONE<<SRC_MDR),32'hDEAD_BEEF,  1, 5'd3,  1, 1, 8'd3, 32'hDEAD_BEEF,2'd3};
    vt[7]  = '{1'b0,1'b0, (ONE<<SRC_R3)|(ONE<<SRC_MDR),32'hDEAD_BEEF,  1, 5'd3,  1, 1, 8'd4, 32'hDEAD_BEEF,2'd3};
    vt[8]  = '{1'b0,1'b0, (ONE<<SRC_R3)|(ONE<<SRC_MDR),32'hDEAD_BEEF,  1, 5'd3,  1, 1, 8'd5, 32'hDEAD_BEEF,2'd3};
    vt[9]  = '{1'b0,1'b0, (ONE<<SRC_R3)|(ONE<<SRC_MDR),32'hDEAD_BEEF,  1, 5'd3,  1, 1, 8'd6, 32'hDEAD_BEEF,2'd3};
    vt[10] = '{1'b0,1'b1, (ONE<<SRC_R1)|(ONE<<SRC_R2), 32'h1111_0001,  1, 5'd1,  1, 1, 8'd1, 32'h1111_0001,2'd1};
    vt[11] = '{1'b0,1'b1, '0,                          32'h1111_0001,  0, 5'd1,  0, 0, 8'd0, 32'h0,        2'd0};
    vt[12] = '{1'b0,1'b0, ONE<<SRC_R1,                 32'h1111_0001,  1, 5'd1,  0, 0, 8'd0, 32'h1111_0001,2'd0};
    vt[13] = '{1'b0,1'b0, ONE<<SRC_R2,                 32'h2222_0002,  1, 5'd2,  0, 0, 8'd0, 32'h2222_0002,2'd0};
    vt[14] = '{1'b0,1'b0, ONE<<SRC_R15,                32'hF0F0_000F,  1, 5'd15, 0, 0, 8'd0, 32'hF0F0_000F,2'd0};
    vt[15] = '{1'b0,1'b0, (ONE<<SRC_R15)|(ONE<<SRC_HI),32'hF0F0_000F,  1, 5'd15, 1, 1, 8'd1, 32'hF0F0_000F,2'd1};
    vt[16] = '{1'b1,1'b0, ONE<<SRC_R15,                32'h0,          0, 5'd0,  0, 0, 8'd0, 32'h0,        2'd0};
    vt[17] = '{1'b0,1'b0, ONE<<SRC_C,                  32'hC000_0017,  1, 5'd23, 0, 0, 8'd0, 32'hC000_0017,2'd0};
    vt[18] = '{1'b0,1'b0, '1,                          32'hC000_0000,  1, 5'd0,  1, 1, 8'd1, 32'hC000_0000,2'd1};

    // Reset held three edges with random strobes: everything must read zero.
    clear   = 1'b1;
    err_clr = 1'b0;
    src_out = '0;
    for (int c = 0; c < 3; c++) begin
      src_out = N'($urandom);
      @(posedge clk); #1;
      chk("rst_bus",   c, ifa.bus, 32'h0);
      chk("rst_vld",   c, 32'(ifa.bus_valid), 32'h0);
      chk("rst_src",   c, 32'(ifa.bus_src), 32'h0);
      chk("rst_conf",  c, 32'(ifa.conflict), 32'h0);
      chk("rst_stk",   c, 32'(ifa.conflict_sticky), 32'h0);
      chk("rst_cnt",   c, 32'(ifa.conflict_count), 32'h0);
      chk("rst_cnt_b", c, 32'(ifb.conflict_count), 32'h0);
    end

    for (int v = 0; v < NV; v++) begin
      clear   = vt[v].clr;
      err_clr = vt[v].eclr;
      src_out = vt[v].so;
      @(posedge clk); #1;
      chk("bus_a",    v, ifa.bus, vt[v].bus_a);
      chk("valid_a",  v, 32'(ifa.bus_valid), 32'(vt[v].vld));
      chk("src_a",    v, 32'(ifa.bus_src), 32'(vt[v].src));
      chk("conf_a",   v, 32'(ifa.conflict), 32'(vt[v].conf));
      chk("sticky_a", v, 32'(ifa.conflict_sticky), 32'(vt[v].sticky));
      chk("count_a",  v, 32'(ifa.conflict_count), 32'(vt[v].cnt_a));
      chk("bus_b",    v, ifb.bus, vt[v].bus_b);
      chk("valid_b",  v, 32'(ifb.bus_valid), 32'(vt[v].vld));
      chk("src_b",    v, 32'(ifb.bus_src), 32'(vt[v].src));
      chk("sticky_b", v, 32'(ifb.conflict_sticky), 32'(vt[v].sticky));
      chk("count_b",  v, 32'(ifb.conflict_count), 32'(vt[v].cnt_b));
    end

    // Data changing under a held strobe must follow with one cycle of latency.
    clear   = 1'b0;
    err_clr = 1'b0;
    src_out = ONE << SRC_INPORT;
    set_src(SRC_INPORT, 32'hA5A5_0001);
    @(posedge clk); #1;
    set_src(SRC_INPORT, 32'h5A5A_0002);
    chk("lat_old", 0, ifa.bus, 32'hA5A5_0001);
    chk("lat_src", 0, 32'(ifa.bus_src), 32'(SRC_INPORT));
    @(posedge clk); #1;
    chk("lat_new", 1, ifa.bus, 32'h5A5A_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
